// File: rtl/instr_cycle_sequencer.sv
// instr_cycle_sequencer
// Multi-cycle phase sequencer for the 72-bit datapath. Walks each instruction
// through FETCH, DECODE, EXECUTE, optional WRITEBACK and PC_UPDATE, and drives
// the per-phase enables. It also provides a memory-write handshake with a
// bounded wait, a HALT opcode and a retired-instruction counter.
module instr_cycle_sequencer #(
  parameter int                  OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF,
  parameter int                  WB_TIMEOUT  = 8,
  parameter int                  CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch_en,
  input  logic                jump_en,
  input  logic                write_en,
  input  logic                alu_flag,
  input  logic                mem_ack,
  output logic                pc_update,
  output logic [1:0]          pc_load_sel,
  output logic                if_latch,
  output logic                reg_read_en,
  output logic                alu_en,
  output logic                mem_wr_req,
  output logic                busy,
  output logic                halted,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state
);

  // Wait counter only has to reach WB_TIMEOUT-1; keep at least one bit.
  localparam int WAIT_W = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_PC_UPDATE = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                take_jump_q, take_jump_d;
  logic                take_branch_q, take_branch_d;
  logic [CNT_W-1:0]    count_q;

  logic                pc_update_q;
  logic [1:0]          pc_load_sel_q;
  logic                if_latch_q;
  logic                reg_read_en_q;
  logic                alu_en_q;
  logic                mem_wr_req_q;
  logic                busy_q;
  logic                halted_q;
  logic                timeout_err_q;

  // Next-state and decision logic. The branch/jump decision is captured in
  // EXECUTE so the control flags only need to be valid in DECODE/EXECUTE;
  // WRITEBACK then holds the decision until PC_UPDATE consumes it.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    take_jump_d   = take_jump_q;
    take_branch_d = take_branch_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == HALT_OPCODE) state_d = S_HALT;
        else                       state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        take_jump_d   = jump_en;
        take_branch_d = branch_en & alu_flag;
        if (write_en) begin
          state_d = S_WRITEBACK;
          wait_d  = '0;
        end else begin
          state_d = S_PC_UPDATE;
        end
      end
      S_WRITEBACK: begin
        // An ack in the last allowed cycle still completes the write.
        if (mem_ack) begin
          state_d = S_PC_UPDATE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_PC_UPDATE: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, decision and counter registers; outputs are registered from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      take_jump_q   <= 1'b0;
      take_branch_q <= 1'b0;
      count_q       <= '0;
      pc_update_q   <= 1'b0;
      pc_load_sel_q <= 2'b00;
      if_latch_q    <= 1'b0;
      reg_read_en_q <= 1'b0;
      alu_en_q      <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      take_jump_q   <= take_jump_d;
      take_branch_q <= take_branch_d;
      // The instruction retires on the edge that leaves PC_UPDATE.
      if (state_q == S_PC_UPDATE) count_q <= count_q + 1'b1;
      pc_update_q   <= (state_d == S_PC_UPDATE);
      if (state_d == S_PC_UPDATE) begin
        // Jump outranks a taken branch.
        if (take_jump_d)        pc_load_sel_q <= 2'b10;
        else if (take_branch_d) pc_load_sel_q <= 2'b01;
        else                    pc_load_sel_q <= 2'b00;
      end else begin
        pc_load_sel_q <= 2'b00;
      end
      if_latch_q    <= (state_d == S_FETCH);
      reg_read_en_q <= (state_d == S_DECODE);
      alu_en_q      <= (state_d == S_EXECUTE);
      mem_wr_req_q  <= (state_d == S_WRITEBACK);
      busy_q        <= (state_d == S_FETCH)     || (state_d == S_DECODE) ||
                       (state_d == S_EXECUTE)   || (state_d == S_WRITEBACK) ||
                       (state_d == S_PC_UPDATE);
      halted_q      <= (state_d == S_HALT);
      timeout_err_q <= (state_d == S_ERROR);
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign pc_update   = pc_update_q;
  assign pc_load_sel = pc_load_sel_q;
  assign if_latch    = if_latch_q;
  assign reg_read_en = reg_read_en_q;
  assign alu_en      = alu_en_q;
  assign mem_wr_req  = mem_wr_req_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;

endmodule
